// File: rtl/dmem_responder.sv
// Data-memory responder for the pipelined CPU: word-addressed store/load with a fixed
// number of wait states, a one-cycle Ready pulse, an Err flag, and Busy for the hazard unit.
// Ports: CLK/Reset (sync, active-high); Req, MemWrite, AddrData, WriteData (captured in IDLE);
//        ReadData (registered load result), Ready (completion pulse), Busy (state != IDLE),
//        Err (misaligned/out-of-range, valid with Ready).
module dmem_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Req,
  input  logic        MemWrite,
  input  logic [31:0] AddrData,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Busy,
  output logic        Err
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [31:0] SPAN    = 32'(4 * DEPTH);
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  // Access currently being decoded. In IDLE with WAIT_CYCLES=0 the access enters
  // DONE on the accepting edge itself, so the live inputs must be used there;
  // everywhere else only the latched copies matter.
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [31:0] offset;
  logic        misaligned;
  logic        out_of_range;
  logic        acc_err;
  logic [AW-1:0] idx;
  logic        enter_done;

  always_comb begin
    acc_we    = (state_q == S_IDLE) ? MemWrite  : we_q;
    acc_addr  = (state_q == S_IDLE) ? AddrData  : addr_q;
    acc_wdata = (state_q == S_IDLE) ? WriteData : wdata_q;
    // Addresses below BASE_ADDR wrap to huge offsets and fall out of range.
    offset       = acc_addr - BASE_ADDR;
    misaligned   = (acc_addr[1:0] != 2'b00);
    out_of_range = (offset >= SPAN);
    acc_err      = misaligned | out_of_range;
    idx          = offset[AW+1:2];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (Req) begin
          cnt_d = WAIT_LD;
          if (WAIT_CYCLES == 0) begin
            state_d    = S_DONE;
            enter_done = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // <= rather than == so a corrupted zero count cannot wedge the FSM.
        if (cnt_q <= 4'd1) begin
          state_d    = S_DONE;
          enter_done = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Completion results: loads update ReadData (0 on error), stores leave it alone.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (enter_done) begin
      err_d = acc_err;
      if (!acc_we) begin
        rdata_d = acc_err ? 32'd0 : mem[idx];
      end
    end else if (state_q == S_DONE) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (state_q == S_IDLE && Req) begin
        we_q    <= MemWrite;
        addr_q  <= AddrData;
        wdata_q <= WriteData;
      end
    end
  end

  // Storage is not reset. The commit happens on the edge entering DONE, so a
  // Reset during WAIT drops the store entirely.
  always_ff @(posedge CLK) begin
    if (!Reset && enter_done && acc_we && !acc_err) begin
      mem[idx] <= acc_wdata;
    end
  end

  assign ReadData = rdata_q;
  assign Ready    = (state_q == S_DONE);
  assign Busy     = (state_q != S_IDLE);
  assign Err      = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Req, MemWrite;
  logic [31:0] AddrData, WriteData;
  logic [31:0] ReadData;
  logic        Ready, Busy, Err;

  logic        Req1, MemWrite1;
  logic [31:0] AddrData1, WriteData1;
  logic [31:0] ReadData1;
  logic        Ready1, Busy1, Err1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  dmem_responder #(.DEPTH(256), .WAIT_CYCLES(2), .BASE_ADDR(32'h0000_1000)) u0 (
    .CLK(CLK), .Reset(Reset), .Req(Req), .MemWrite(MemWrite),
    .AddrData(AddrData), .WriteData(WriteData),
    .ReadData(ReadData), .Ready(Ready), .Busy(Busy), .Err(Err)
  );

  dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_1000)) u1 (
    .CLK(CLK), .Reset(Reset), .Req(Req1), .MemWrite(MemWrite1),
    .AddrData(AddrData1), .WriteData(WriteData1),
    .ReadData(ReadData1), .Ready(Ready1), .Busy(Busy1), .Err(Err1)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Waits (bounded) for Ready on u0, checking Busy every cycle; n = cycles since accept.
  task automatic wait_ready(output int n);
    n = 1;
    while (!Ready && n < 20) begin
      chk("busy_in_wait", {31'd0, Busy}, 32'd1);
      step();
      n++;
    end
  endtask

  // One access on u0, started in IDLE at #1 after an edge. Inputs are scrambled
  // right after acceptance to make sure only the latched copies are used.
  task automatic do_access(input string nm, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rd,
                           input logic exp_err);
    int n;
    Req = 1'b1; MemWrite = we; AddrData = addr; WriteData = wdata;
    step();
    Req = 1'b0; MemWrite = ~we; AddrData = 32'h0000_1000; WriteData = 32'h5555_AAAA;
    wait_ready(n);
    chk({nm, "_latency"}, n, 32'd3);
    chk({nm, "_busy_done"}, {31'd0, Busy}, 32'd1);
    chk({nm, "_rdata"}, ReadData, exp_rd);
    chk({nm, "_err"}, {31'd0, Err}, {31'd0, exp_err});
    step();
    chk({nm, "_idle_busy"}, {31'd0, Busy}, 32'd0);
    chk({nm, "_idle_ready"}, {31'd0, Ready}, 32'd0);
    chk({nm, "_idle_err"}, {31'd0, Err}, 32'd0);
  endtask

  logic [31:0] held_addr [3];
  logic [31:0] held_exp  [3];

  initial begin
    int n;
    int last_cyc;

    vecs[0]  = '{1'b1, 32'h0000_1004, 32'hCAFE_0001, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_1004, 32'h0,         32'hCAFE_0001, 1'b0};
    vecs[2]  = '{1'b0, 32'h0000_1008, 32'h0,         32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_1002, 32'h1234_5678, 32'h0000_0000, 1'b1};
    vecs[4]  = '{1'b0, 32'h0000_1000, 32'h0,         32'h0000_0000, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0FFC, 32'h0,         32'h0000_0000, 1'b1};
    vecs[6]  = '{1'b1, 32'h0000_13FC, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[7]  = '{1'b0, 32'h0000_13FC, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[8]  = '{1'b0, 32'h0000_1400, 32'h0,         32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b0, 32'h0000_1004, 32'h0,         32'hCAFE_0001, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_1010, 32'h1111_2222, 32'hCAFE_0001, 1'b0};
    vecs[11] = '{1'b0, 32'h0000_1010, 32'h0,         32'h1111_2222, 1'b0};

    held_addr[0] = 32'h0000_1004; held_exp[0] = 32'hCAFE_0001;
    held_addr[1] = 32'h0000_13FC; held_exp[1] = 32'hDEAD_BEEF;
    held_addr[2] = 32'h0000_1008; held_exp[2] = 32'h0000_0000;

    Reset = 1'b1;
    Req = 1'b0; MemWrite = 1'b0; AddrData = 32'd0; WriteData = 32'd0;
    Req1 = 1'b0; MemWrite1 = 1'b0; AddrData1 = 32'd0; WriteData1 = 32'd0;
    step();
    step();
    Reset = 1'b0;

    chk("rst_rdata", ReadData, 32'd0);
    chk("rst_ready", {31'd0, Ready}, 32'd0);
    chk("rst_busy",  {31'd0, Busy},  32'd0);
    chk("rst_err",   {31'd0, Err},   32'd0);
    chk("rst_busy1", {31'd0, Busy1}, 32'd0);

    foreach (vecs[i]) begin
      do_access($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                vecs[i].exp_rd, vecs[i].exp_err);
    end

    // Reset during the WAIT cycle of a store: no Ready, store dropped.
    Req = 1'b1; MemWrite = 1'b1; AddrData = 32'h0000_1010; WriteData = 32'h9999_9999;
    step();
    Req = 1'b0;
    chk("abort_busy_wait", {31'd0, Busy}, 32'd1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("abort_busy", {31'd0, Busy}, 32'd0);
    chk("abort_ready", {31'd0, Ready}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("abort_no_ready", {31'd0, Ready}, 32'd0);
      step();
    end
    do_access("abort_reload", 1'b0, 32'h0000_1010, 32'h0, 32'h1111_2222, 1'b0);

    // Req held high: back-to-back loads, address changed during WAIT.
    Req = 1'b1; MemWrite = 1'b0; AddrData = held_addr[0];
    step();
    last_cyc = 0;
    for (int k = 0; k < 3; k++) begin
      AddrData = (k < 2) ? held_addr[k+1] : 32'h0000_0FFC;
      wait_ready(n);
      chk($sformatf("held%0d_ready", k), {31'd0, Ready}, 32'd1);
      chk($sformatf("held%0d_rdata", k), ReadData, held_exp[k]);
      chk($sformatf("held%0d_err", k), {31'd0, Err}, 32'd0);
      if (k > 0) chk($sformatf("held%0d_spacing", k), cyc - last_cyc, 32'd4);
      last_cyc = cyc;
      if (k < 2) begin
        step();
        chk($sformatf("held%0d_idle", k), {31'd0, Busy}, 32'd0);
        step();
      end else begin
        Req = 1'b0;
      end
    end
    step();
    chk("held_end_busy", {31'd0, Busy}, 32'd0);
    step();
    chk("held_end_idle", {31'd0, Busy}, 32'd0);

    // Zero-wait instance: Ready the cycle right after acceptance.
    Req1 = 1'b1; MemWrite1 = 1'b1; AddrData1 = 32'h0000_1020; WriteData1 = 32'hA5A5_A5A5;
    step();
    Req1 = 1'b0;
    chk("w0_st_ready", {31'd0, Ready1}, 32'd1);
    chk("w0_st_busy",  {31'd0, Busy1},  32'd1);
    chk("w0_st_err",   {31'd0, Err1},   32'd0);
    chk("w0_st_rdata", ReadData1, 32'd0);
    step();
    chk("w0_st_busy_after", {31'd0, Busy1}, 32'd0);
    Req1 = 1'b1; MemWrite1 = 1'b0;
    step();
    Req1 = 1'b0; AddrData1 = 32'h0000_1024;
    chk("w0_ld_ready", {31'd0, Ready1}, 32'd1);
    chk("w0_ld_rdata", ReadData1, 32'hA5A5_A5A5);
    step();
    chk("w0_ld_busy_after",  {31'd0, Busy1},  32'd0);
    chk("w0_ld_ready_after", {31'd0, Ready1}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipelined CPU.
- Serves the CPU's load/store requests (MemWrite, AddrData, WriteData) with a configurable number of wait states.
- Returns ReadData and a one-cycle completion pulse, and drives Busy so the hazard unit can stall the pipeline.
- Flags misaligned and out-of-range accesses instead of corrupting memory.

Parameters:
- DEPTH, 256: number of 32-bit words stored; power of two, 16 to 4096.
- WAIT_CYCLES, 2: wait states between request acceptance and completion; range 0 to 15.
- BASE_ADDR, 32'h0000_1000: byte address of word 0; must be word-aligned.

Ports:
- CLK  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- Req  input  1  access request from the CPU memory stage; sampled only in IDLE.
- MemWrite  input  1  1 = store, 0 = load; captured with Req.
- AddrData  input  32  byte address; captured with Req.
- WriteData  input  32  store data; captured with Req.
- ReadData  output  32  load result; registered, held until the next completion.
- Ready  output  1  one-cycle pulse marking completion of the accepted access.
- Busy  output  1  high whenever state is not IDLE; CPU stalls the memory stage while high.
- Err  output  1  valid only with Ready; 1 = misaligned or out-of-range access.

Behaviour:
- Reset values: state IDLE, wait counter 0, ReadData 0, Ready 0, Busy 0, Err 0.
- Memory array is not cleared by Reset; it powers up as zero in simulation.
- Reset mid-operation aborts the access. A pending store is dropped and no Ready is issued.
- The state machine has three states: IDLE, WAIT, DONE.
- IDLE:
  - If Req=1 at the edge, latch MemWrite, AddrData and WriteData, and load the counter with WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0, otherwise go to DONE.
  - If Req=0, stay in IDLE.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reads 1, go to DONE on the next edge.
- DONE:
  - Ready=1 for exactly this cycle, then return to IDLE unconditionally.
  - Req is ignored while in DONE.
- Latency: Ready is high during the cycle that begins WAIT_CYCLES+1 edges after the accepting edge. With WAIT_CYCLES=0, Ready is high the cycle right after acceptance.
- Throughput: at most one access per WAIT_CYCLES+2 cycles.
- Busy is combinational and equals (state != IDLE), so it is high in WAIT and DONE.
- Req, MemWrite, AddrData and WriteData changing after acceptance have no effect. Only the latched copies are used.
- Address decode:
  - offset = latched AddrData - BASE_ADDR (32-bit unsigned subtraction).
  - Misaligned when AddrData[1:0] != 0.
  - Out of range when offset >= 4*DEPTH; underflow wraps to a large value, so it also counts as out of range.
  - index = offset[log2(DEPTH)+1:2].
- Store commits to mem[index] on the edge that enters DONE, only if the access is valid. ReadData keeps its old value on stores.
- Load: ReadData <= mem[index] on the edge that enters DONE.
- Error case, set on the same edge: Err=1, the store is suppressed, and a load returns ReadData=0.
- Err returns to 0 on the edge leaving DONE.
- A load of the address just stored returns the new data, because the store has committed before the later request is accepted.
- A Req held high continuously re-triggers in IDLE. Each access is counted once per IDLE acceptance.

Test Plan:
- Reset, then store AddrData=32'h0000_1004, WriteData=32'hCAFE_0001 with WAIT_CYCLES=2 -> Busy high for 3 cycles, Ready pulse in the 3rd cycle after accept, Err=0, ReadData unchanged (0).
- Load 32'h0000_1004 -> Ready 3 cycles after accept with ReadData=32'hCAFE_0001. A load of 32'h0000_1008 returns 0.
- Store to 32'h0000_1002 (misaligned) then load 32'h0000_1000 -> store gives Ready with Err=1. The following load returns 0, showing the store was suppressed.
- Load 32'h0000_0FFC and 32'h0000_1400 (DEPTH=256) -> both give Err=1 with ReadData=0. Load 32'h0000_13FC gives Err=0.
- Hold Req=1 continuously with loads, changing AddrData during WAIT -> completions spaced every 4 cycles. Each result matches the address latched at acceptance.
- Assert Reset in the WAIT cycle of a store to 32'h0000_1010 -> no Ready, Busy=0 the next cycle. A later load of 32'h0000_1010 returns its prior contents.
- Instance with WAIT_CYCLES=0: load -> Ready the cycle right after acceptance, Busy high for exactly 1 cycle.
